// File: rtl/serial_link_arbiter_pkg.sv
// serial_link_pkg: shared state encoding and frame constants for the serial link arbiter
package serial_link_pkg;
  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
  localparam logic [1:0] PREAMBLE = 2'b11;
  localparam int PREAMBLE_W = 2;
  localparam int FRAME_W = 32;
endpackage

// File: rtl/serial_link_arbiter_if.sv
// serial_link_arbiter_if: requester handshake plus serial lane and status
interface serial_link_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int PAYLOAD_W = 30
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*PAYLOAD_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic serial_out;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic busy;
  logic frame_done;
  modport master(output req_valid, req_data, input req_ready, serial_out, grant_id, busy, frame_done);
  modport slave(input req_valid, req_data, output req_ready, serial_out, grant_id, busy, frame_done);
endinterface

// File: rtl/serial_link_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot plus encoded index
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);
  // walk offsets from far to near so the closest valid requester to ptr wins
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      idx = req[(int'(ptr) + i) % NUM_REQ] ? ID_W'((int'(ptr) + i) % NUM_REQ) : idx;
    gnt = (|req) ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter: round-robin grant of one word, framed as {11, payload} then an idle gap
module serial_link_arbiter
  import serial_link_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PAYLOAD_W = FRAME_W - PREAMBLE_W,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  serial_link_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PAYLOAD_W + GAP_CYCLES + PREAMBLE_W);
  state_t state;
  logic [PAYLOAD_W-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [ID_W-1:0] rr_ptr, win;
  logic [NUM_REQ-1:0] gnt;
  logic accept;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(win));
  // ready is masked by rst so it drops immediately when reset is asserted
  assign bus.req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign accept = |bus.req_ready;
  assign bus.busy = state != IDLE;
  // serial_out is loaded with the bit due in the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shift_reg <= '0;
      bit_cnt <= '0;
      rr_ptr <= '0;
      bus.serial_out <= 1'b0;
      bus.grant_id <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.serial_out <= accept ? PREAMBLE[1] : 1'b0;
          if (accept) begin
            state <= PRE;
            shift_reg <= bus.req_data[int'(win)*PAYLOAD_W +: PAYLOAD_W];
            bus.grant_id <= win;
            rr_ptr <= ID_W'((int'(win) + 1) % NUM_REQ);
            bit_cnt <= '0;
          end
        end
        PRE: begin
          if (bit_cnt == CNT_W'(PREAMBLE_W - 1)) begin
            state <= DATA;
            bit_cnt <= '0;
            bus.serial_out <= shift_reg[PAYLOAD_W-1];
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            bus.serial_out <= PREAMBLE[0];
          end
        end
        DATA: begin
          shift_reg <= shift_reg << 1;
          if (bit_cnt == CNT_W'(PAYLOAD_W - 1)) begin
            state <= GAP;
            bit_cnt <= '0;
            bus.serial_out <= 1'b0;
            bus.frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            bus.serial_out <= shift_reg[PAYLOAD_W-2];
          end
        end
        GAP: begin
          bus.frame_done <= 1'b0;
          bus.serial_out <= 1'b0;
          if (bit_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end
endmodule
